// File: rtl/mips_fetch.sv
// Instruction fetch unit: requests the word at pc, holds it for the datapath, then steps to next pc.
// Optional fetch-timeout fault is enabled by defining MIPS_FETCH_TIMEOUT_EN.
module mips_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_out,
    output logic        imem_req_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_data_in,
    input  logic        advance_in,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        zero_in,
    input  logic [31:0] rs_data_in,
    output logic [31:0] instr_out,
    output logic [5:0]  op_out,
    output logic [5:0]  func_out,
    output logic        instr_valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr_out,
    output logic        fault_out
);

    typedef enum logic [1:0] {IDLE, REQ, VALID, FAULT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] next_pc_d;
    logic [5:0]  op;
    logic [5:0]  func;

    assign op       = instr_q[31:26];
    assign func     = instr_q[5:0];
    assign pc_plus4 = pc_q + 32'd4;

    // Jumps beat branches; jump_in on a non-jump opcode falls through to the branch test.
    always_comb begin
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        next_pc_d  = pc_plus4;
        if (jump_in && (op == 6'd2 || op == 6'd3)) begin
            next_pc_d = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (jump_in && op == 6'd0 && func == 6'd8) begin
            next_pc_d = rs_data_in & 32'hFFFF_FFFC;
        end else if (branch_in && ((op == 6'd4 && zero_in) || (op == 6'd5 && !zero_in))) begin
            next_pc_d = pc_plus4 + branch_off;
        end
    end

`ifdef MIPS_FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    cnt_q   <= '0;
                end
                REQ: begin
                    // A ready in the expiry cycle still wins over the fault.
                    if (imem_ready_in) begin
                        instr_q <= imem_data_in;
                        state_q <= VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= FAULT;
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                VALID: begin
                    if (advance_in) begin
                        pc_q    <= next_pc_d;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= FAULT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign fault_out = fault_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (imem_ready_in) begin
                        instr_q <= imem_data_in;
                        state_q <= VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (advance_in) begin
                        pc_q    <= next_pc_d;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FAULT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fault_out = 1'b0;
`endif

    assign imem_addr_out   = pc_q;
    assign pc_out          = pc_q;
    assign link_addr_out   = pc_q + 32'd4;
    assign imem_req_out    = req_q;
    assign instr_valid_out = valid_q;
    assign instr_out       = instr_q;
    assign op_out          = instr_q[31:26];
    assign func_out        = instr_q[5:0];

endmodule
